// File: rtl/mont_pkg.sv
// Constants and state type for the Montgomery datapath: the chunked adder,
// the radix-4 shift register and the controller all import this.
package mont_pkg;

  localparam int unsigned OP_W    = 1027;
  localparam int unsigned RES_W   = OP_W + 1;
  localparam int unsigned CHUNK_W = 257;
  localparam int unsigned N_CHUNK = RES_W / CHUNK_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunk_add.sv
// Combinational W-bit adder with carry-in and carry-out; the only carry chain
// in the chunked adder, kept apart so it can be timed or swapped on its own.
module chunk_add
  import mont_pkg::*;
#(
  parameter int unsigned W = CHUNK_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] ext;

  always_comb begin
    ext    = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
    sum_o  = ext[W-1:0];
    cout_o = ext[W];
  end

endmodule

// File: rtl/chunked_mpadder.sv
// Chunk-serial 1028-bit adder/subtractor: one CHUNK_W-bit slice per cycle
// through a single shared chunk_add, result valid on the done pulse.
module chunked_mpadder
  import mont_pkg::*;
(
  input  logic             clk,
  input  logic             restn,
  input  logic             start,
  input  logic             subtract,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result
);

  state_t             state_q, state_d;
  logic [RES_W-1:0]   op_a_q, op_a_d;
  logic [RES_W-1:0]   op_b_q, op_b_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [1:0]         idx_q, idx_d;

  int unsigned        base;
  logic [CHUNK_W-1:0] a_chunk, b_chunk, s_chunk;
  logic               c_out;

  always_comb begin
    base    = 32'(idx_q) * CHUNK_W;
    a_chunk = op_a_q[base +: CHUNK_W];
    b_chunk = op_b_q[base +: CHUNK_W];
  end

  chunk_add #(.W(CHUNK_W)) u_chunk_add (
    .a_i    (a_chunk),
    .b_i    (b_chunk),
    .cin_i  (carry_q),
    .sum_o  (s_chunk),
    .cout_o (c_out)
  );

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction as A + ~B + 1: B inverted over the full result width,
          // the +1 enters as the initial carry.
          op_a_d  = {1'b0, in_a};
          op_b_d  = subtract ? ~{1'b0, in_b} : {1'b0, in_b};
          carry_d = subtract;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[base +: CHUNK_W] = s_chunk;
        carry_d                = c_out;
        idx_d                  = idx_q + 2'd1;
        if (idx_q == 2'(N_CHUNK - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = acc_q;

endmodule

// File: tb/tb_chunked_mpadder.sv
// Self-checking bench for chunked_mpadder against a plain-arithmetic model.
module tb_chunked_mpadder;
  import mont_pkg::*;

  logic             clk;
  logic             restn;
  logic             start;
  logic             subtract;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] result;

  int n_checks;
  int n_fail;

  chunked_mpadder dut (
    .clk      (clk),
    .restn    (restn),
    .start    (start),
    .subtract (subtract),
    .in_a     (in_a),
    .in_b     (in_b),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RES_W-1:0] model(input logic [OP_W-1:0] a,
                                             input logic [OP_W-1:0] b,
                                             input logic sub);
    logic [RES_W-1:0] ea, eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return sub ? (ea - eb) : (ea + eb);
  endfunction

  function automatic logic [OP_W-1:0] rand_op();
    logic [33*32-1:0] w;
    int unsigned      kind;
    for (int i = 0; i < 33; i++) w[i*32 +: 32] = $urandom;
    kind = $urandom_range(0, 5);
    if (kind == 0) return '1;
    if (kind == 1) return OP_W'(w[31:0]);
    return w[OP_W-1:0];
  endfunction

  // Start asserted in the cycle ending at edge 0; returns at the negedge of cycle 1
  // with operands scrambled to show they are not re-sampled.
  task automatic launch(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic sub);
    @(negedge clk);
    in_a = a; in_b = b; subtract = sub; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_a = rand_op(); in_b = rand_op(); subtract = 1'($urandom);
  endtask

  // Samples cycles 1..ncyc at negedges (already at cycle 1 on entry).
  task automatic observe(input int ncyc, output int ndone, output int done_cyc,
                         output logic [RES_W-1:0] res, output logic [15:0] busy_mask);
    ndone = 0; done_cyc = -1; res = '0; busy_mask = '0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) @(negedge clk);
      busy_mask[c] = busy;
      if (done) begin
        ndone++; done_cyc = c; res = result;
      end
    end
  endtask

  task automatic test_reset();
    restn = 1'b0; start = 1'b0; subtract = 1'b0; in_a = '0; in_b = '0;
    #2;
    n_checks++;
    if ({busy, done} !== 2'b00 || result !== '0) begin
      n_fail++; $display("FAIL reset_init: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    @(negedge clk); restn = 1'b1;
  endtask

  task automatic test_carry_chain();
    int nd, dc; logic [RES_W-1:0] r, exp; logic [15:0] bm;
    launch('1, '1, 1'b0);
    observe(6, nd, dc, r, bm);
    exp = model('1, '1, 1'b0);
    n_checks++;
    if (nd !== 1 || dc !== 5) begin
      n_fail++; $display("FAIL carry_done_cycle: count=%0d cycle=%0d expected 1 at 5", nd, dc);
    end
    n_checks++;
    if (r !== exp) begin
      n_fail++; $display("FAIL carry_result: got %h expected %h", r, exp);
    end
    n_checks++;
    if (bm[6:1] !== 6'b011111) begin
      n_fail++; $display("FAIL carry_busy: got %b expected 011111", bm[6:1]);
    end
  endtask

  task automatic test_subtract();
    int nd, dc; logic [RES_W-1:0] r, exp_lt; logic [15:0] bm;
    launch(OP_W'(5), OP_W'(3), 1'b1);
    observe(6, nd, dc, r, bm);
    n_checks++;
    if (nd !== 1 || dc !== 5 || r !== RES_W'(2) || r[RES_W-1] !== 1'b0) begin
      n_fail++; $display("FAIL sub_ge: count=%0d cycle=%0d result=%h expected 1 5 2", nd, dc, r);
    end
    launch(OP_W'(3), OP_W'(5), 1'b1);
    observe(6, nd, dc, r, bm);
    exp_lt = '1; exp_lt[0] = 1'b0;
    n_checks++;
    if (nd !== 1 || dc !== 5 || r !== exp_lt) begin
      n_fail++; $display("FAIL sub_lt: count=%0d cycle=%0d result=%h expected %h", nd, dc, r, exp_lt);
    end
    n_checks++;
    if (r[RES_W-1] !== 1'b1) begin
      n_fail++; $display("FAIL sub_lt_sign: got %b expected 1", r[RES_W-1]);
    end
  endtask

  task automatic test_random();
    int nd, dc; logic [RES_W-1:0] r, exp; logic [15:0] bm;
    logic [OP_W-1:0] a, b; logic s;
    for (int k = 0; k < 10; k++) begin
      a = rand_op(); b = rand_op(); s = 1'($urandom);
      exp = model(a, b, s);
      launch(a, b, s);
      observe(6, nd, dc, r, bm);
      n_checks++;
      if (nd !== 1 || dc !== 5 || r !== exp) begin
        n_fail++; $display("FAIL random_%0d sub=%b: count=%0d cycle=%0d result=%h expected %h",
                           k, s, nd, dc, r, exp);
      end
    end
  endtask

  task automatic test_ignored_start();
    int nd, dc; logic [RES_W-1:0] r; logic [15:0] bm;
    launch(OP_W'(1), OP_W'(1), 1'b0);
    nd = 0; dc = -1; r = '0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 2) begin start = 1'b1; in_a = OP_W'(7); in_b = OP_W'(1); subtract = 1'b0; end
      if (c == 3) start = 1'b0;
      if (done) begin nd++; dc = c; r = result; end
    end
    n_checks++;
    if (nd !== 1 || dc !== 5 || r !== RES_W'(2)) begin
      n_fail++; $display("FAIL ignored_start: count=%0d cycle=%0d result=%h expected 1 5 2", nd, dc, r);
    end
    // back-to-back: launch's first negedge is cycle 6 of the previous op
    launch(OP_W'(100), OP_W'(23), 1'b0);
    observe(6, nd, dc, r, bm);
    n_checks++;
    if (nd !== 1 || dc !== 5 || r !== RES_W'(123)) begin
      n_fail++; $display("FAIL back_to_back: count=%0d cycle=%0d result=%h expected 1 5 7b", nd, dc, r);
    end
  endtask

  task automatic test_reset_mid();
    int nd, dc; logic [RES_W-1:0] r; logic [15:0] bm;
    launch('1, OP_W'(9), 1'b0);
    @(negedge clk);                  // cycle 2
    @(posedge clk); #2;              // inside cycle 3
    restn = 1'b0;
    #1;
    n_checks++;
    if ({busy, done} !== 2'b00 || result !== '0) begin
      n_fail++; $display("FAIL reset_mid_async: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    @(negedge clk); restn = 1'b1;
    observe(8, nd, dc, r, bm);
    n_checks++;
    if (nd !== 0 || bm[8:1] !== 8'h00 || result !== '0) begin
      n_fail++; $display("FAIL reset_mid_abort: dones=%0d busy=%b result=%h expected 0 00000000 0", nd, bm[8:1], result);
    end
    launch(OP_W'('h10), OP_W'('h20), 1'b0);
    observe(6, nd, dc, r, bm);
    n_checks++;
    if (nd !== 1 || dc !== 5 || r !== RES_W'('h30)) begin
      n_fail++; $display("FAIL reset_mid_recover: count=%0d cycle=%0d result=%h expected 1 5 30", nd, dc, r);
    end
  endtask

  task automatic test_result_hold();
    // Result from the last op must persist while idle with start low.
    repeat (4) @(negedge clk);
    n_checks++;
    if (result !== RES_W'('h30) || busy !== 1'b0) begin
      n_fail++; $display("FAIL result_hold: result=%h busy=%b expected 30 0", result, busy);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_carry_chain();
    test_subtract();
    test_random();
    test_ignored_start();
    test_reset_mid();
    test_result_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
